frame_mux2to1: RTL and testbench

Frame-aware 2:1 merge stage for the Ethernet switch datapath: the egress-side counterpart of the 1-to-2 demultiplexer. It combines two 9-bit word streams into one output stream with round-robin arbitration. Once a frame is granted, it forwards that frame whole and never interleaves words from the other source. It sits in front of each egress port, merging switched traffic and enforcing a maximum frame length so a runaway source cannot lock the port.

---
 rtl/frame_mux2to1_if.sv | 34 +++
 rtl/frame_mux2to1.sv | 135 +++++++++++++
 tb/tb_frame_mux2to1.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_mux2to1_if.sv
// Stream bundle for the 2:1 frame merge: two word sources in, one merged word stream out.
// Bit W-1 of every data word marks the last word of a frame.
interface frame_mux2to1_if #(
  parameter int W = 9
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_src;

  modport slave (
    input  in0_data, in0_valid,
    output in0_ready,
    input  in1_data, in1_valid,
    output in1_ready,
    output out_data, out_valid, out_src,
    input  out_ready
  );

  modport master (
    output in0_data, in0_valid,
    input  in0_ready,
    output in1_data, in1_valid,
    input  in1_ready,
    input  out_data, out_valid, out_src,
    output out_ready
  );
endinterface

// File: rtl/frame_mux2to1.sv
// Frame-aware round-robin 2:1 merge with registered output and max-length truncation.
// A granted frame is forwarded whole; an overlong frame is cut, flagged, and its tail dropped.
module frame_mux2to1 #(
  parameter int W       = 9,
  parameter int MAX_LEN = 1536,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_mux2to1_if.slave bus,
  output logic          trunc_err,
  output logic [CW-1:0] frames0,
  output logic [CW-1:0] frames1
);

  localparam int WCW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOCK0 = 3'd1,
    LOCK1 = 3'd2,
    DROP0 = 3'd3,
    DROP1 = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           last_grant;
  logic [WCW-1:0] wcnt;

  logic           drain_ok;
  logic           sel_src;
  logic           sel_valid;
  logic [W-1:0]   sel_data;
  logic           fwd;
  logic [W-1:0]   fwd_data;
  logic           frame_done;
  logic           trunc_now;

  // Output register can take a word when empty or being drained this cycle.
  assign drain_ok  = !bus.out_valid || bus.out_ready;
  assign sel_src   = (state == LOCK1) || (state == DROP1);
  assign sel_valid = sel_src ? bus.in1_valid : bus.in0_valid;
  assign sel_data  = sel_src ? bus.in1_data  : bus.in0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    fwd           = 1'b0;
    fwd_data      = sel_data;
    frame_done    = 1'b0;
    trunc_now     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in0_valid && bus.in1_valid) begin
          state_nxt = last_grant ? LOCK0 : LOCK1;
        end else if (bus.in0_valid) begin
          state_nxt = LOCK0;
        end else if (bus.in1_valid) begin
          state_nxt = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        bus.in0_ready = (state == LOCK0) && drain_ok;
        bus.in1_ready = (state == LOCK1) && drain_ok;
        if (sel_valid && drain_ok) begin
          fwd = 1'b1;
          if (sel_data[W-1]) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else if (wcnt == WCW'(MAX_LEN - 1)) begin
            // Cut the frame here so downstream still sees a properly terminated frame.
            fwd_data[W-1] = 1'b1;
            frame_done    = 1'b1;
            trunc_now     = 1'b1;
            state_nxt     = sel_src ? DROP1 : DROP0;
          end
        end
      end
      DROP0, DROP1: begin
        bus.in0_ready = (state == DROP0);
        bus.in1_ready = (state == DROP1);
        if (sel_valid && sel_data[W-1]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_src   <= 1'b0;
      last_grant    <= 1'b1;
      wcnt          <= '0;
      trunc_err     <= 1'b0;
      frames0       <= '0;
      frames1       <= '0;
    end else begin
      trunc_err <= trunc_now;
      if (fwd) begin
        bus.out_data  <= fwd_data;
        bus.out_valid <= 1'b1;
        bus.out_src   <= sel_src;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (frame_done) begin
        wcnt       <= '0;
        last_grant <= sel_src;
        if (sel_src) begin
          frames1 <= frames1 + CW'(1);
        end else begin
          frames0 <= frames0 + CW'(1);
        end
      end else if (fwd) begin
        wcnt <= wcnt + WCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_mux2to1.sv
// Directed bench for frame_mux2to1 with a frame-level reference model and literal sequence checks.
module tb_frame_mux2to1;
  localparam int W       = 9;
  localparam int MAX_LEN = 4;
  localparam int CW      = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          trunc_err;
  logic [CW-1:0] frames0;
  logic [CW-1:0] frames1;

  always #5 clk = ~clk;

  frame_mux2to1_if #(.W(W)) bus ();

  frame_mux2to1 #(.W(W), .MAX_LEN(MAX_LEN), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .trunc_err (trunc_err),
    .frames0   (frames0),
    .frames1   (frames1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected output words as {src, word}, derived from accepted input words.
  logic [9:0]    mq[$];
  int            m_cnt[2]    = '{0, 0};
  bit            m_drop[2]   = '{0, 0};
  logic [CW-1:0] m_frames[2] = '{16'd0, 16'd0};
  bit            m_trunc     = 1'b0;

  logic [9:0]    log_e[$];
  int            log_c[$];
  logic [9:0]    exp_e[$];
  int            trunc_seen = 0;

  task automatic model_word(input int s, input logic [8:0] w);
    if (m_drop[s]) begin
      if (w[8]) m_drop[s] = 1'b0;
    end else begin
      m_cnt[s]++;
      if (w[8]) begin
        mq.push_back({s[0], w});
        m_frames[s]++;
        m_cnt[s] = 0;
      end else if (m_cnt[s] == MAX_LEN) begin
        mq.push_back({s[0], 1'b1, w[7:0]});
        m_frames[s]++;
        m_cnt[s]  = 0;
        m_drop[s] = 1'b1;
        m_trunc   = 1'b1;
      end else begin
        mq.push_back({s[0], w});
      end
    end
  endtask

  always @(negedge rst_n) begin
    mq.delete();
    m_cnt    = '{0, 0};
    m_drop   = '{0, 0};
    m_frames = '{16'd0, 16'd0};
    m_trunc  = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("trunc_err", trunc_err, m_trunc);
      m_trunc = 1'b0;
      if (trunc_err) trunc_seen++;
      check("frames0", frames0, m_frames[0]);
      check("frames1", frames1, m_frames[1]);
      check("ready_excl", bus.in0_ready && bus.in1_ready, 0);
      check("out_valid", bus.out_valid, mq.size() != 0);
      if (bus.out_valid && mq.size() != 0) begin
        check("out_word", {bus.out_src, bus.out_data}, mq[0]);
        if (bus.out_ready) begin
          void'(mq.pop_front());
          log_e.push_back({bus.out_src, bus.out_data});
          log_c.push_back(cyc);
        end
      end
      if (bus.in0_valid && bus.in0_ready) model_word(0, bus.in0_data);
      if (bus.in1_valid && bus.in1_ready) model_word(1, bus.in1_data);
    end
  end

  logic [8:0] sq0[$];
  logic [8:0] sq1[$];
  bit         abort = 1'b0;

  task automatic drive(input int s);
    logic [8:0] w;
    int         budget;
    bit         acc;
    while (!abort && ((s == 0) ? sq0.size() : sq1.size()) > 0) begin
      w = (s == 0) ? sq0[0] : sq1[0];
      if (s == 0) begin
        bus.in0_data = w; bus.in0_valid = 1'b1;
      end else begin
        bus.in1_data = w; bus.in1_valid = 1'b1;
      end
      acc    = 1'b0;
      budget = 0;
      while (!acc && !abort && budget < 100) begin
        @(negedge clk);
        acc = (s == 0) ? bus.in0_ready : bus.in1_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (s == 0) void'(sq0.pop_front()); else void'(sq1.pop_front());
      if (!abort) begin
        check($sformatf("drive%0d_accept", s), acc, 1);
        if (!acc) begin
          if (s == 0) sq0.delete(); else sq1.delete();
        end
      end
    end
    if (s == 0) bus.in0_valid = 1'b0; else bus.in1_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_log();
    log_e.delete();
    log_c.delete();
    trunc_seen = 0;
  endtask

  task automatic expect_log(input string name);
    check({name, "_len"}, log_e.size(), exp_e.size());
    for (int i = 0; i < exp_e.size() && i < log_e.size(); i++)
      check($sformatf("%s_w%0d", name, i), log_e[i], exp_e[i]);
  endtask

  task automatic expect_gap(input string name, input int i, input int gap);
    if (log_c.size() > i) check($sformatf("%s_gap%0d", name, i), log_c[i] - log_c[i-1], gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic t_single();
    clear_log();
    sq0 = '{9'h011, 9'h022, 9'h133};
    fork
      drive(0);
      begin
        int n;
        n = 0;
        while (!bus.out_valid && n < 10) begin
          @(posedge clk); #1;
          n++;
        end
        check("latency_edges", n, 2);
      end
    join
    tick(4);
    exp_e = '{10'h011, 10'h022, 10'h133};
    expect_log("single");
    expect_gap("single", 1, 1);
    expect_gap("single", 2, 1);
    check("single_frames0", frames0, 1);
  endtask

  task automatic t_tie();
    do_reset();
    clear_log();
    sq0 = '{9'h0AA, 9'h1AB};
    sq1 = '{9'h0CC, 9'h1CD};
    fork
      drive(0);
      drive(1);
    join
    tick(4);
    exp_e = '{10'h0AA, 10'h1AB, 10'h2CC, 10'h3CD};
    expect_log("tie");
    expect_gap("tie", 1, 1);
    expect_gap("tie", 2, 2);
    expect_gap("tie", 3, 1);
    check("tie_frames0", frames0, 1);
    check("tie_frames1", frames1, 1);
  endtask

  task automatic t_rr();
    clear_log();
    sq0 = '{9'h100, 9'h101, 9'h102};
    sq1 = '{9'h1F0, 9'h1F1, 9'h1F2};
    fork
      drive(0);
      drive(1);
    join
    tick(4);
    exp_e = '{10'h100, 10'h3F0, 10'h101, 10'h3F1, 10'h102, 10'h3F2};
    expect_log("rr");
    for (int i = 1; i < 6; i++) expect_gap("rr", i, 2);
    check("rr_frames0", frames0, 4);
    check("rr_frames1", frames1, 4);
  endtask

  task automatic t_backpressure();
    clear_log();
    sq0 = '{9'h041, 9'h042, 9'h043, 9'h144};
    fork
      drive(0);
      begin
        int n;
        n = 0;
        while (!(bus.out_valid && bus.out_data == 9'h042) && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        check("bp_seen", n < 50, 1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_data", bus.out_data, 9'h042);
          check("bp_src", bus.out_src, 0);
          check("bp_in0_ready", bus.in0_ready, 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    tick(4);
    exp_e = '{10'h041, 10'h042, 10'h043, 10'h144};
    expect_log("bp");
    check("bp_frames0", frames0, 5);
  endtask

  task automatic t_trunc();
    clear_log();
    sq1 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
    drive(1);
    tick(4);
    exp_e = '{10'h201, 10'h202, 10'h203, 10'h304};
    expect_log("trunc");
    check("trunc_pulses", trunc_seen, 1);
    check("trunc_frames1", frames1, 5);
    check("trunc_idle_r0", bus.in0_ready, 0);
    check("trunc_idle_r1", bus.in1_ready, 0);
    clear_log();
    sq1 = '{9'h1EE};
    drive(1);
    tick(4);
    exp_e = '{10'h3EE};
    expect_log("post_trunc");
    check("post_trunc_frames1", frames1, 6);
  endtask

  task automatic t_async_reset();
    clear_log();
    sq0 = '{9'h051, 9'h052, 9'h053, 9'h154};
    fork
      drive(0);
      begin
        int n;
        n = 0;
        while (!(bus.out_valid && bus.out_data == 9'h051) && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        check("rst_seen", n < 50, 1);
        #2;
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in0_ready", bus.in0_ready, 0);
        check("rst_in1_ready", bus.in1_ready, 0);
        check("rst_frames0", frames0, 0);
      end
    join
    sq0.delete();
    tick(2);
    rst_n = 1'b1;
    abort = 1'b0;
    tick(1);
    clear_log();
    sq0 = '{9'h061, 9'h162};
    sq1 = '{9'h071, 9'h172};
    fork
      drive(0);
      drive(1);
    join
    tick(4);
    exp_e = '{10'h061, 10'h162, 10'h271, 10'h372};
    expect_log("after_rst");
  endtask

  initial begin
    bus.in0_data  = '0;
    bus.in0_valid = 1'b0;
    bus.in1_data  = '0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(2);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_src", bus.out_src, 0);
    check("reset_in0_ready", bus.in0_ready, 0);
    check("reset_in1_ready", bus.in1_ready, 0);
    check("reset_trunc", trunc_err, 0);
    check("reset_frames", {frames1, frames0}, 0);
    rst_n = 1'b1;
    tick(1);
    t_single();
    t_tie();
    t_rr();
    t_backpressure();
    t_trunc();
    t_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
